wide_add_seq: RTL
=================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 Parameter: NWORD, default 4, number of 16-bit slices; operand width W = 16*NWORD; legal range 2..8.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept a request.
- a  in  W  operand A.
- b  in  W  operand B.
- sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  W  result.
- cout  out  1  carry out of bit W-1 (for sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.
REQ-003 One clock; reset SHALL be synchronous and active-high (clk, rst).

Function
REQ-004 One shared 16-bit carry-lookahead slice adder SHALL perform all arithmetic, one slice per cycle, LSB slice first.
REQ-005 States SHALL be IDLE, RUN, DONE.
REQ-006 IDLE: in_ready=1, out_valid=0; on in_valid=1 at a clk edge, latch a, b XOR {W{sub}}, carry<=sub, idx<=0, go to RUN.
REQ-007 RUN: in_ready=0; each cycle add slice idx of latched operands with carry; store 16-bit result into sum slice idx; carry<=slice carry out; idx<=idx+1.
REQ-008 RUN SHALL last exactly NWORD cycles; after slice NWORD-1, go to DONE.
REQ-009 Latency: out_valid SHALL rise NWORD+1 cycles after the accepting edge.
REQ-010 DONE: out_valid=1; sum, cout, ovf stable; in_ready=0; on out_ready=1 at a clk edge, go to IDLE.
REQ-011 cout SHALL equal carry out of slice NWORD-1.
REQ-012 ovf = (a[W-1] XNOR b'[W-1]) AND (sum[W-1] XOR a[W-1]), where b' is the inverted-or-not operand; ovf is valid for add and sub.
REQ-013 in_valid SHALL be ignored outside IDLE; no request queuing; throughput is one result per NWORD+2 cycles minimum.
REQ-014 out_ready outside DONE SHALL have no effect.
REQ-015 Back-to-back: in the cycle after DONE exits, IDLE SHALL accept a new request (in_ready=1).
REQ-016 sum/cout/ovf SHALL hold last result in IDLE until the next accept.
REQ-017 idx width = clog2(NWORD); no wrap beyond NWORD-1 SHALL occur.

Reset
REQ-018 rst=1 at a clk edge SHALL force IDLE from any state, including mid-RUN; the in-flight operation is discarded.
REQ-019 Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry=0.
REQ-020 A request presented while rst=1 SHALL NOT be accepted.

Structure
REQ-021 Shared package add_seq_pkg SHALL hold SLICE_W=16 and the state enum {IDLE, RUN, DONE}.
REQ-022 Exactly one sub-module: the team's existing CLA16 (16-bit CLA with cin/cout), instantiated once; the slice mux and the sum register live in wide_add_seq.
REQ-023 No combinational path from in_valid or out_ready to any output.

Verification
REQ-024 Carry ripple: a=0x0000_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x0001_0000_0000_0000, cout=0, ovf=0, out_valid at accept+5.
REQ-025 Borrow: a=0, b=1, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0.
REQ-026 Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
REQ-027 Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid, sum held; in_ready=0; in_valid pulses ignored.
REQ-028 Reset mid-RUN: rst at accept+2 -> next cycle IDLE, in_ready=1, out_valid=0, sum=0; following request completes correctly.
REQ-029 Back-to-back: two requests, second held valid -> accepted one cycle after first handshake, both results correct.

Source files
------------

// File: rtl/add_seq_pkg.sv
// add_seq_pkg
// Shared definitions for the sequential wide adder. It holds the slice width
// that the CLA and the top-level slice mux use, and the controller state
// encoding.
package add_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wide_add_seq_cla16.sv
// cla16
// 16-bit two-level carry-lookahead adder. Bits are grouped into four 4-bit
// blocks. Block generate/propagate terms give the block carries directly, and
// those carries then produce the bit carries inside each block.
// Ports:
//   a_i, b_i : 16-bit addends
//   cin_i    : carry into bit 0
//   sum_o    : 16-bit sum
//   cout_o   : carry out of bit 15
module cla16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Block carries are formed in parallel from cin, not rippled block to block.
    gc[0] = cin_i;
    gc[1] = gg[0] | (gp[0] & cin_i);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin_i);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum_o  = p ^ c;
  assign cout_o = gc[4];

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq
// Sequential W = 16*NWORD bit adder/subtractor. It uses one shared 16-bit CLA
// slice and processes one slice per cycle, starting with the LSB slice.
// Subtraction is done as A + ~B + 1: the carry register is seeded with 'sub'.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : request handshake (accepted only in IDLE)
//   a, b, sub           : operands and operation select (1 = A-B)
//   out_valid/out_ready : result handshake (held in DONE)
//   sum, cout, ovf      : result, carry out of the MSB, signed overflow
module wide_add_seq
  import add_seq_pkg::*;
#(
  parameter int NWORD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SLICE_W*NWORD-1:0] a,
  input  logic [SLICE_W*NWORD-1:0] b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SLICE_W*NWORD-1:0] sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int W     = SLICE_W * NWORD;
  localparam int IDX_W = $clog2(NWORD);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, b_q;
  logic [W-1:0]       sum_q;
  logic               carry_q;
  logic               cout_q;
  logic               ovf_q;
  logic [IDX_W-1:0]   idx_q;

  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_cout;
  logic               last;

  assign last = (idx_q == IDX_W'(NWORD - 1));

  // Slice mux: the low four offset bits are zero because slices are 16 bits wide.
  assign sl_a = a_q[{idx_q, 4'd0} +: SLICE_W];
  assign sl_b = b_q[{idx_q, 4'd0} +: SLICE_W];

  cla16 u_cla (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .cin_i  (carry_q),
    .sum_o  (sl_sum),
    .cout_o (sl_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so there is no combinational
  // path from the handshake inputs to any output.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Operand registers are data only. They are loaded on accept and not reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b ^ {W{sub}};
    end
  end

  // Slice datapath control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            carry_q <= sub;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[{idx_q, 4'd0} +: SLICE_W] <= sl_sum;
          carry_q <= sl_cout;
          if (last) begin
            cout_q <= sl_cout;
            // Operands of equal sign that give a result of the opposite sign.
            ovf_q  <= (a_q[W-1] ~^ b_q[W-1]) & (sl_sum[SLICE_W-1] ^ a_q[W-1]);
          end else begin
            idx_q  <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
